// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Turns a parallel word into one asynchronous UART frame: a start bit, the
// data bits LSB first, an optional parity bit, and a stop bit. i_clk is
// already the baud clock, so every state lasts exactly one i_clk cycle.
//
// Ports
//   i_clk        : baud-rate clock (one cycle per bit)
//   i_rst        : synchronous reset, active-high
//   i_data       : word to send, latched on accept
//   i_data_valid : transmit request
//   i_par_en     : 1 appends a parity bit (latched on accept)
//   i_par_typ    : 0 even parity, 1 odd parity (latched on accept)
//   o_tx_out     : serial line, idles high (registered)
//   o_busy       : 1 while a request cannot be accepted (registered)
//
// Build option
//   UART_TX_PARITY_EN : when defined, the PARITY state and parity logic are
//   built in. When undefined, i_par_en/i_par_typ are ignored and every frame
//   is start + data + stop.

module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  tx_r;
  logic                  busy_r;
  logic                  accept_s;

`ifdef UART_TX_PARITY_EN
  logic                  par_en_r;
  logic                  par_bit_r;

  // Parity bit for a word: XOR of all bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  odd);
    return (^word) ^ odd;
  endfunction
`else
  // Parity inputs are intentionally ignored in this build.
  logic                  par_unused_s;
  assign par_unused_s = i_par_en ^ i_par_typ;
`endif

  // A new word is taken when idle or during the stop bit (back-to-back).
  assign accept_s = i_data_valid && ((state_r == IDLE) || (state_r == STOP));

  assign o_tx_out = tx_r;
  assign o_busy   = busy_r;

  // Frame sequencer: the line level and busy flag are registered together
  // with the state being entered, so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      shift_r   <= {DATA_WIDTH{1'b0}};
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, STOP: begin
          if (accept_s) begin
            shift_r   <= i_data;
`ifdef UART_TX_PARITY_EN
            par_en_r  <= i_par_en;
            par_bit_r <= calc_parity(i_data, i_par_typ);
`endif
            state_r   <= START;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        START: begin
          // Present bit 0 now; cnt_r tracks the index of the bit on the line.
          state_r <= DATA;
          cnt_r   <= {CNT_W{1'b0}};
          tx_r    <= shift_r[0];
          shift_r <= shift_r >> 1'b1;
          busy_r  <= 1'b1;
        end
        DATA: begin
          if (cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_r) begin
              state_r <= PARITY;
              tx_r    <= par_bit_r;
              busy_r  <= 1'b1;
            end else begin
              state_r <= STOP;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
`else
            state_r <= STOP;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
`endif
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            tx_r    <= shift_r[0];
            shift_r <= shift_r >> 1'b1;
            busy_r  <= 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_r <= STOP;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
`endif
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer (DATA_WIDTH = 8). Expected line levels
// are queued when a frame is launched and popped one per cycle on the
// falling edge. Honours UART_TX_PARITY_EN the same way the design does.

module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       par_en;
  logic       par_typ;
  logic       tx;
  logic       busy;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [0:10] seq;
    int          len;
  } vec_t;

  typedef struct {
    logic tx;
    logic busy;
    int   tag;
    int   pos;
  } exp_t;

  exp_t q[$];
  vec_t vec[7];
  int   checks;
  int   failures;

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (valid),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .o_tx_out     (tx),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue a frame: line levels in cycle order; busy high on all but the stop bit.
  task automatic push_seq(input logic [0:10] seq, input int len, input int tag);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.tx   = seq[i];
      e.busy = (i < len - 1);
      e.tag  = tag;
      e.pos  = i;
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n, input int tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tx   = 1'b1;
      e.busy = 1'b0;
      e.tag  = tag;
      e.pos  = i;
      q.push_back(e);
    end
  endtask

  // Advance n cycles, comparing outputs at each falling edge against the queue.
  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (tx !== e.tx) begin
          failures++;
          $display("FAIL tx tag=%0d pos=%0d got=%b exp=%b", e.tag, e.pos, tx, e.tx);
        end
        checks++;
        if (busy !== e.busy) begin
          failures++;
          $display("FAIL busy tag=%0d pos=%0d got=%b exp=%b", e.tag, e.pos, busy, e.busy);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Launch one frame from idle, then scramble the inputs while it is in flight.
  task automatic do_frame(input logic [7:0] d, input logic pe, input logic pt,
                          input logic [0:10] seq, input int len, input int tag);
    push_idle(1, tag);
    data    = d;
    par_en  = pe;
    par_typ = pt;
    valid   = 1'b1;
    run(1);
    valid   = 1'b0;
    data    = 8'($urandom);
    par_en  = 1'($urandom);
    par_typ = 1'($urandom);
    push_seq(seq, len, tag);
    run(len);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid    = 1'b0;
    data     = 8'h00;
    par_en   = 1'b0;
    par_typ  = 1'b0;

    // Reset held for two edges, then 20 idle cycles.
    run(1);
    push_idle(1, 0);
    run(1);
    rst = 1'b0;
    push_idle(20, 0);
    run(20);

    // Frame table: hand-derived line sequences (start, LSB-first data, [parity], stop).
    vec[0] = '{8'hA5, 1'b0, 1'b0, 11'b01010010111, 10};
    vec[1] = '{8'hA5, 1'b1, 1'b0, PAR ? 11'b01010010101 : 11'b01010010111, PAR ? 11 : 10};
    vec[2] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, PAR ? 11 : 10};
    vec[3] = '{8'h00, 1'b0, 1'b1, 11'b00000000011, 10};
    vec[4] = '{8'hFF, 1'b1, 1'b0, PAR ? 11'b01111111101 : 11'b01111111111, PAR ? 11 : 10};
    vec[5] = '{8'h07, 1'b1, 1'b0, 11'b01110000011, PAR ? 11 : 10};
    vec[6] = '{8'h80, 1'b1, 1'b1, PAR ? 11'b00000000101 : 11'b00000000111, PAR ? 11 : 10};
    for (int i = 0; i < 7; i++) begin
      do_frame(vec[i].data, vec[i].pe, vec[i].pt, vec[i].seq, vec[i].len, 100 + i);
    end
    push_idle(2, 199);
    run(2);

    // Back-to-back: 0x01 then 0xFF, valid held through the first frame.
    push_idle(1, 20);
    data    = 8'h01;
    par_en  = 1'b0;
    par_typ = 1'b0;
    valid   = 1'b1;
    run(1);
    data = 8'hFF;
    push_seq(11'b01000000011, 10, 20);
    run(10);
    valid = 1'b0;
    push_seq(11'b01111111111, 10, 21);
    run(10);
    push_idle(2, 22);
    run(2);

    // Input change and ignored request mid-frame: 0x0F must go out unchanged.
    push_idle(1, 30);
    data   = 8'h0F;
    par_en = 1'b0;
    valid  = 1'b1;
    run(1);
    valid = 1'b0;
    push_seq(11'b01111000011, 10, 30);
    run(2);
    data   = 8'hF0;
    par_en = 1'b1;
    valid  = 1'b1;
    run(1);
    valid = 1'b0;
    run(7);
    push_idle(3, 31);
    run(3);

    // Reset during the 4th data bit of 0x3C, with a simultaneous request.
    push_idle(1, 40);
    data   = 8'h3C;
    par_en = 1'b0;
    valid  = 1'b1;
    run(1);
    valid = 1'b0;
    push_seq(11'b00011000000, 5, 40);
    // Pin busy high for all five queued entries (start + data bits 0..3).
    q[4].busy = 1'b1;
    run(4);
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    run(1);
    rst   = 1'b0;
    valid = 1'b0;
    push_idle(3, 41);
    run(3);
    do_frame(8'h55, 1'b0, 1'b0, 11'b01010101011, 10, 42);
    push_idle(2, 43);
    run(2);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
